// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : opcodes and FSM state encoding for seq_calculator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam logic [1:0] OPR_ADD = 2'b00;
  localparam logic [1:0] OPR_SUB = 2'b01;
  localparam logic [1:0] OPR_MUL = 2'b10;
  localparam logic [1:0] OPR_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } calc_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_divider.sv
// ---------------------------------------------------------------------------
// serial_divider : restoring divider, one quotient bit per cycle, MSB first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int            C_CW   = $clog2(WIDTH);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  logic             r_busy;
  logic [C_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // Partial remainder stays below the divisor, so a borrow out of bit WIDTH
  // is exactly the "does not fit" condition.
  always_comb begin
    w_shift  = {r_r, r_q[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_d};
    w_fit    = ~w_diff[WIDTH];
    w_r_next = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_q_next = {r_q[WIDTH-2:0], w_fit};
  end

  assign done      = r_busy && (r_cnt == C_LAST);
  assign quotient  = w_q_next;
  assign remainder = w_r_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_q    <= dividend;
      r_r    <= '0;
      r_d    <= divisor;
    end else if (r_busy) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_calculator.sv
// ---------------------------------------------------------------------------
// seq_calculator : handshaked add/sub/mul/div calculator with serial divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   first_input_number,
  input  logic [WIDTH-1:0]   second_input_number,
  input  logic [1:0]         operation,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  calc_state_t r_state;
  calc_state_t w_next;

  logic [2*WIDTH-1:0] r_result;
  logic               r_div_by_zero;
  logic               w_accept;
  logic               w_b_zero;
  logic               w_div_start;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_alu;

  assign in_ready    = (r_state == ST_IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_b_zero    = (second_input_number == '0);
  assign w_div_start = w_accept && (operation == OPR_DIV) && !w_b_zero;
  assign out_valid   = (r_state == ST_DONE);
  assign result      = r_result;
  assign div_by_zero = r_div_by_zero;

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (first_input_number),
    .divisor   (second_input_number),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_div_start ? ST_DIV : ST_DONE;
      ST_DIV:  if (w_div_done) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Single-cycle operations; bit WIDTH of add/sub is carry/borrow.
  always_comb begin
    w_sum = {1'b0, first_input_number} + {1'b0, second_input_number};
    w_dif = {1'b0, first_input_number} - {1'b0, second_input_number};
    w_alu = '0;
    case (operation)
      OPR_ADD: w_alu = {{(WIDTH-1){1'b0}}, w_sum};
      OPR_SUB: w_alu = {{(WIDTH-1){1'b0}}, w_dif};
      OPR_MUL: w_alu = first_input_number * second_input_number;
      default: w_alu = {first_input_number, {WIDTH{1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result      <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept && !w_div_start) begin
      r_result      <= w_alu;
      r_div_by_zero <= (operation == OPR_DIV);
    end else if (w_div_done) begin
      r_result      <= {w_rem, w_quo};
      r_div_by_zero <= 1'b0;
    end
  end

endmodule

`default_nettype wire
